// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera stream transmitter.
// Holds the sequencer state enum, pixel width, byte order and bar colours.
package cam_pkg;

  localparam int PIX_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } cam_state_e;

  // Byte phase within a pixel: low byte {0,B}, then high byte {R,G}.
  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

  localparam logic [PIX_W-1:0] BAR_WHITE   = 12'hFFF;
  localparam logic [PIX_W-1:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [PIX_W-1:0] BAR_CYAN    = 12'h0FF;
  localparam logic [PIX_W-1:0] BAR_GREEN   = 12'h0F0;
  localparam logic [PIX_W-1:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [PIX_W-1:0] BAR_RED     = 12'hF00;
  localparam logic [PIX_W-1:0] BAR_BLUE    = 12'h00F;
  localparam logic [PIX_W-1:0] BAR_BLACK   = 12'h000;

  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_tx_timing.sv
// cam_tx_timing: frame/line sequencer. In: PCLK, RESET (async high), EN.
// Out: in_vs, in_active, byte0/byte1 strobes, frame_end, pix_x (pattern builds).
module cam_tx_timing
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 176,
  parameter int V_ACTIVE    = 144,
  parameter int H_BLANK     = 32,
  parameter int VSYNC_LINES = 1,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       EN,
  output logic       in_vs,
  output logic       in_active,
  output logic       byte0,
  output logic       byte1,
`ifdef CAM_TX_TEST_PATTERN_EN
  output logic [8:0] pix_x,
`endif
  output logic       frame_end
);

  localparam int LINE    = 2*H_ACTIVE + H_BLANK;
  localparam int VS_END  = VSYNC_LINES - 1;
  localparam int VB_END  = VSYNC_LINES + V_BACK - 1;
  localparam int ACT_END = VB_END + V_ACTIVE;
  localparam int VF_END  = ACT_END + V_FRONT;

  cam_state_e state;
  // pcnt: cycle within the line; lcnt: line within the frame.
  logic [9:0] pcnt;
  logic [8:0] lcnt;
  logic       eol;

  assign eol = (pcnt == 10'(LINE-1));

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      pcnt  <= '0;
      lcnt  <= '0;
    end else begin
      pcnt <= eol ? '0 : pcnt + 10'd1;
      if (eol) lcnt <= lcnt + 9'd1;
      unique case (state)
        ST_IDLE: begin
          pcnt <= '0;
          lcnt <= '0;
          if (EN) state <= ST_VS;
        end
        ST_VS:
          if (eol && lcnt == 9'(VS_END)) state <= ST_VBACK;
        ST_VBACK:
          if (eol && lcnt == 9'(VB_END)) state <= ST_ACTIVE;
        ST_ACTIVE:
          if (pcnt == 10'(2*H_ACTIVE-1)) state <= ST_HBLANK;
        ST_HBLANK:
          if (eol)
            state <= (lcnt == 9'(ACT_END)) ? ST_VFRONT : ST_ACTIVE;
        ST_VFRONT:
          if (eol && lcnt == 9'(VF_END)) begin
            lcnt  <= '0;
            state <= EN ? ST_VS : ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_vs     = (state == ST_VS);
  assign in_active = (state == ST_ACTIVE);
  assign byte0     = in_active && (pcnt[0] == BYTE_LO);
  assign byte1     = in_active && (pcnt[0] == BYTE_HI);
  assign frame_end = (state == ST_VFRONT) && eol
                     && (lcnt == 9'(VF_END));
`ifdef CAM_TX_TEST_PATTERN_EN
  assign pix_x = pcnt[9:1];
`endif

endmodule

// File: rtl/cam_stream_tx.sv
// cam_stream_tx: 12-bit RGB444 pixels to an 8-bit VSYNC/HREF camera bus.
// In: PCLK, RESET, EN, PIX_DATA/PIX_VALID (+PAT_SEL if CAM_TX_TEST_PATTERN_EN).
// Out: PIX_READY, DATA, VSYNC, HREF, UNDERRUN (sticky), FRAME_DONE.
module cam_stream_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 176,
  parameter int V_ACTIVE    = 144,
  parameter int H_BLANK     = 32,
  parameter int VSYNC_LINES = 1,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic             PCLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [PIX_W-1:0] PIX_DATA,
  input  logic             PIX_VALID,
`ifdef CAM_TX_TEST_PATTERN_EN
  input  logic             PAT_SEL,
`endif
  output logic             PIX_READY,
  output logic [7:0]       DATA,
  output logic             VSYNC,
  output logic             HREF,
  output logic             UNDERRUN,
  output logic             FRAME_DONE
);

  logic             in_vs;
  logic             in_active;
  logic             byte0;
  logic             byte1;
  logic             frame_end;
  logic             pat;
  logic             full;
  logic [PIX_W-1:0] hold;
  logic [7:0]       cur_hi;
  logic [PIX_W-1:0] src;
  logic             starve;
  logic             xfer;

`ifdef CAM_TX_TEST_PATTERN_EN
  logic [8:0] pix_x;
  logic [2:0] bar;
  assign pat = PAT_SEL;
  assign bar = 3'((int'(pix_x) * 8) / H_ACTIVE);
`else
  assign pat = 1'b0;
`endif

  cam_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .PCLK      (PCLK),
    .RESET     (RESET),
    .EN        (EN),
    .in_vs     (in_vs),
    .in_active (in_active),
    .byte0     (byte0),
    .byte1     (byte1),
`ifdef CAM_TX_TEST_PATTERN_EN
    .pix_x     (pix_x),
`endif
    .frame_end (frame_end)
  );

  assign PIX_READY = ~RESET & ~full & ~pat;
  assign xfer      = PIX_VALID & PIX_READY;

  // Pixel taken at byte 0: holding register, black on starvation,
  // or the colour bar when the pattern source is selected.
  always_comb begin
    src    = full ? hold : '0;
    starve = ~full;
`ifdef CAM_TX_TEST_PATTERN_EN
    if (PAT_SEL) begin
      src    = bar_color(bar);
      starve = 1'b0;
    end
`endif
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      full       <= 1'b0;
      hold       <= '0;
      cur_hi     <= '0;
      DATA       <= '0;
      HREF       <= 1'b0;
      VSYNC      <= 1'b0;
      FRAME_DONE <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      HREF       <= in_active;
      VSYNC      <= in_vs;
      FRAME_DONE <= frame_end;
      // A write only lands in an empty register, so a write on a
      // byte-0 cycle is held for the next pixel.
      if (xfer) begin
        hold <= PIX_DATA;
        full <= 1'b1;
      end else if (byte0 && !pat) begin
        full <= 1'b0;
      end
      if (byte0) begin
        cur_hi <= src[11:4];
        if (starve) UNDERRUN <= 1'b1;
      end
      unique case (1'b1)
        byte0:   DATA <= {4'h0, src[3:0]};
        byte1:   DATA <= cur_hi;
        default: DATA <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// tb_cam_stream_tx: randomized bench for cam_stream_tx with a frame-position
// reference model checked every cycle, plus hand-computed literal checks.
module tb_cam_stream_tx;

  localparam int HA  = 16;
  localparam int VA  = 8;
  localparam int HB  = 4;
  localparam int VSL = 1;
  localparam int VB  = 2;
  localparam int VF  = 2;
  localparam int L   = 2*HA + HB;
  localparam int F   = (VSL+VB+VA+VF) * L;
  localparam int A0  = VSL + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] pdata = '0;
  logic        pat_sel = 1'b0;
  logic        rdy;
  logic [7:0]  data;
  logic        vsync;
  logic        href;
  logic        und;
  logic        fdone;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cam_stream_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .PCLK       (clk),
    .RESET      (rst),
    .EN         (en),
    .PIX_DATA   (pdata),
    .PIX_VALID  (valid),
`ifdef CAM_TX_TEST_PATTERN_EN
    .PAT_SEL    (pat_sel),
`endif
    .PIX_READY  (rdy),
    .DATA       (data),
    .VSYNC      (vsync),
    .HREF       (href),
    .UNDERRUN   (und),
    .FRAME_DONE (fdone)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] bar_ref(int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Reference model: position within the frame drives everything.
  bit          m_run = 0;
  int          m_s = 0;
  bit          m_full = 0;
  logic [11:0] m_hold = '0;
  logic [11:0] m_cur = '0;
  logic [7:0]  e_data = '0;
  bit          e_href = 0;
  bit          e_vsync = 0;
  bit          e_fd = 0;
  bit          e_und = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_s = 0; m_full = 0; m_hold = '0; m_cur = '0;
      e_data = '0; e_href = 0; e_vsync = 0; e_fd = 0; e_und = 0;
    end else begin
      int line, col;
      bit act, b0, rdy_m;
      logic [11:0] px;
      line  = m_s / L;
      col   = m_s % L;
      act   = m_run && line >= A0 && line < A0+VA && col < 2*HA;
      b0    = act && (col % 2 == 0);
      rdy_m = !m_full && !pat_sel;
      e_vsync = m_run && line < VSL;
      e_href  = act;
      e_fd    = m_run && m_s == F-1;
      if (b0) begin
        if (pat_sel) px = bar_ref((col/2)*8/HA);
        else px = m_full ? m_hold : 12'h000;
        if (!m_full && !pat_sel) e_und = 1;
        m_cur  = px;
        e_data = {4'h0, px[3:0]};
      end else if (act) e_data = m_cur[11:4];
      else e_data = 8'h00;
      if (valid && rdy_m) begin
        m_full = 1; m_hold = pdata;
      end else if (b0 && !pat_sel) m_full = 0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_s = 0; end
      end else if (m_s == F-1) begin
        m_s = 0; m_run = en;
      end else m_s++;
    end
  end

  always @(negedge clk) begin
    chk("ready", rdy, !rst && !m_full && !pat_sel);
    chk("vsync", vsync, e_vsync);
    chk("href", href, e_href);
    chk("data", data, e_data);
    chk("frame_done", fdone, e_fd);
    chk("underrun", und, e_und);
  end

  task automatic watch_frame(output int np, output int nbl,
                             output int nbg, output int vsl,
                             output logic [7:0] fb0,
                             output logic [7:0] fb1, output bit ok);
    int hl, gl;
    bit ph;
    hl = 0; gl = 0; ph = 0;
    np = 0; nbl = 0; nbg = 0; vsl = 0; fb0 = 0; fb1 = 0; ok = 0;
    for (int i = 0; i < 2*F+10; i++) begin
      @(negedge clk);
      if (vsync) vsl++;
      if (href) begin
        if (!ph) begin
          if (np > 0 && gl != HB) nbg++;
          np++; hl = 0;
        end
        if (np == 1 && hl == 0) fb0 = data;
        if (np == 1 && hl == 1) fb1 = data;
        hl++;
      end else begin
        if (ph && hl != 2*HA) nbl++;
        if (ph) gl = 0;
        gl++;
      end
      ph = href;
      if (fdone) begin ok = 1; break; end
    end
  endtask

  initial begin
    int np, nbl, nbg, vsl, base, nfd, nrise, n;
    logic [7:0] fb0, fb1;
    bit ok, got, ph, dropped, hit, seen;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_href", href, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_und", und, 0);
    chk("rst_fd", fdone, 0);

    // Frame 1: constant pixel, valid always high.
    pdata = 12'hA5C; valid = 1; en = 1;
    #1 rst = 0;
    #1 chk("ready_after_rst", rdy, 1);
    watch_frame(np, nbl, nbg, vsl, fb0, fb1, ok);
    chk("f1_done", ok, 1);
    chk("f1_href_pulses", np, VA);
    chk("f1_bad_len", nbl, 0);
    chk("f1_bad_gap", nbg, 0);
    chk("f1_vsync_len", vsl, L);
    chk("f1_byte0", fb0, 8'h0C);
    chk("f1_byte1", fb1, 8'hA5);
    chk("f1_rgb332", {fb1[7:5], fb1[3:1], fb0[3:2]}, 8'b101_010_11);
    chk("f1_no_und", und, 0);

    // Frame 2: random pixels, starve line 3 pixel 10.
    base = (A0+3)*L;
    got = 0;
    for (int i = 0; i < 2*F && !got; i++) begin
      @(negedge clk);
      if (m_run && m_s == base+20) chk("und_before", und, 0);
      if (m_run && m_s == base+21) begin
        chk("und_b0", data, 8'h00);
        chk("und_set", und, 1);
      end
      if (m_run && m_s == base+22) chk("und_b1", data, 8'h00);
      if (fdone) got = 1;
      pdata = 12'($urandom);
      valid = !(m_run && m_s >= base+19 && m_s <= base+20);
    end
    chk("f2_done", got, 1);
    chk("und_sticky", und, 1);

    // Frame 3: EN dropped mid active line 5.
    nfd = 0; nrise = 0; ph = 0; dropped = 0;
    for (int i = 0; i < 2*F; i++) begin
      @(negedge clk);
      if (dropped && href && !ph) nrise++;
      ph = href;
      if (fdone) nfd++;
      pdata = 12'($urandom);
      valid = ($urandom % 8) != 0;
      if (m_run && m_s == (A0+5)*L + 10) begin
        en = 0; dropped = 1;
      end
    end
    chk("f3_dropped", dropped, 1);
    chk("f3_fd_once", nfd, 1);
    chk("f3_rest_lines", nrise, VA-6);
    chk("idle_vsync", vsync, 0);
    chk("idle_href", href, 0);

    // Frame 4: reset in the middle of HREF.
    en = 1; hit = 0;
    for (int i = 0; i < 2*F && !hit; i++) begin
      @(negedge clk);
      pdata = 12'($urandom); valid = 1;
      if (m_run && m_s == (A0+1)*L + 5) hit = 1;
    end
    chk("rst_target", hit, 1);
    chk("href_pre_rst", href, 1);
    #2 rst = 1;
    #1;
    chk("async_data", data, 8'h00);
    chk("async_href", href, 0);
    chk("async_und", und, 0);
    chk("async_ready", rdy, 0);
    @(negedge clk);
    #2 rst = 0;
    seen = 0; n = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (vsync) begin seen = 1; n = i; end
    end
    chk("vs_rise_2cyc", seen && n <= 2, 1);

    // Random traffic over two more frames.
    for (int i = 0; i < 2*F; i++) begin
      @(negedge clk);
      pdata = 12'($urandom);
      valid = ($urandom % 4) != 0;
    end

`ifdef CAM_TX_TEST_PATTERN_EN
    pat_sel = 1; seen = 0;
    for (int i = 0; i < 2*F && !seen; i++) begin
      @(negedge clk);
      if (vsync) seen = 1;
    end
    hit = 0;
    for (int i = 0; i < 2*F && !hit; i++) begin
      @(negedge clk);
      if (href) hit = 1;
    end
    chk("pat_href", hit, 1);
    chk("pat_p0_b0", data, 8'h0F);
    chk("pat_ready", rdy, 0);
    @(negedge clk) chk("pat_p0_b1", data, 8'hFF);
    repeat (3) @(negedge clk);
    chk("pat_p2_b0", data, 8'h00);
    @(negedge clk) chk("pat_p2_b1", data, 8'hFF);
    pat_sel = 0;
    repeat (L) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cam_stream_tx.md
CAM_STREAM_TX -- requirements
Module: cam_stream_tx

Interface
REQ-001 Parameter H_ACTIVE, default 176: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 144: active lines per frame.
REQ-003 Parameter H_BLANK, default 32: PCLK cycles with HREF low after each line.
REQ-004 Parameters VSYNC_LINES / V_BACK / V_FRONT, defaults 1 / 2 / 2: line-times of VSYNC high / post-VSYNC idle / post-active idle.
REQ-005 PCLK  in  1  sole clock; all logic on rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 EN  in  1  start/continue frame generation.
REQ-008 PIX_DATA  in  12  pixel {R[3:0],G[3:0],B[3:0]}.
REQ-009 PIX_VALID  in  1  PIX_DATA valid.
REQ-010 PIX_READY  out  1  holding register empty; a transfer occurs when PIX_VALID&PIX_READY.
REQ-011 DATA  out  8  camera byte bus.
REQ-012 VSYNC  out  1  frame sync, high during the VSYNC_LINES period.
REQ-013 HREF  out  1  high while DATA carries active line bytes.
REQ-014 UNDERRUN  out  1  sticky: an active pixel slot found the holding register empty.
REQ-015 FRAME_DONE  out  1  one-cycle pulse at the end of V_FRONT.

Function
REQ-016 Line time L = 2*H_ACTIVE + H_BLANK cycles; every phase counts whole line-times.
REQ-017 FSM states: IDLE, VS, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-018 IDLE -> VS when EN=1; VS lasts VSYNC_LINES*L cycles, then VBACK for V_BACK*L cycles.
REQ-019 ACTIVE: HREF=1 for exactly 2*H_ACTIVE cycles, then HBLANK for H_BLANK cycles.
REQ-020 After HBLANK, go to ACTIVE if line count < V_ACTIVE, else VFRONT for V_FRONT*L cycles.
REQ-021 At VFRONT end, pulse FRAME_DONE; go to VS if EN=1, else IDLE.
REQ-022 Deasserting EN mid-frame does not truncate the frame; the frame completes and stops at IDLE.
REQ-023 Each pixel takes two consecutive cycles: byte 0 = {4'h0,B[3:0]}, byte 1 = {R[3:0],G[3:0]}.
REQ-024 At each byte-0 cycle, load the pixel from the holding register and free it; PIX_READY rises the next cycle.
REQ-025 If the holding register is empty at a byte-0 cycle, transmit 12'h000 for that pixel and set UNDERRUN.
REQ-026 The holding register accepts data in any state, including IDLE and blanking, so it can prefill.
REQ-027 DATA = 8'h00 whenever HREF=0.
REQ-028 DATA, HREF, VSYNC, and FRAME_DONE are registered outputs, with no combinational path from inputs.
REQ-029 Pixel counter is 10 bits and line counter is 9 bits; both clear at VS entry and do not wrap within a frame.
REQ-030 A simultaneous transfer and byte-0 load in the same cycle is legal: the old value is sent and the new value is held.

Reset
REQ-031 RESET forces state IDLE and clears all counters and the holding register.
REQ-032 During RESET: DATA=0, HREF=0, VSYNC=0, PIX_READY=0, UNDERRUN=0, FRAME_DONE=0.
REQ-033 PIX_READY=1 from the first cycle after RESET deasserts.
REQ-034 RESET mid-frame abandons the frame; the next frame begins with VS.

Configuration
REQ-035 Macro CAM_TX_TEST_PATTERN_EN adds input PAT_SEL (1 bit).
REQ-036 With the macro and PAT_SEL=1, pixels come from an internal 8-bar colour pattern (bar = pixel_x*8/H_ACTIVE).
REQ-037 In that mode, PIX_READY=0 and UNDERRUN never sets.
REQ-038 Without the macro, there is no PAT_SEL port and no pattern logic.

Structure
REQ-039 Shared package cam_pkg holds: the FSM state enum, PIX_W=12, byte-order constants, and bar colour constants.
REQ-040 One sub-module cam_tx_timing holds the FSM and counters and outputs phase and byte-0 strobes; pixel and data muxing stay in the top.

Verification
REQ-041 Defaults, EN=1, PIX_VALID held 1 -> per frame: 144 HREF pulses of 352 cycles, 32-cycle gaps, VSYNC high 384 cycles.
REQ-042 PIX_DATA=12'hA5C -> byte 0 = 8'h0C, byte 1 = 8'hA5; a capture-side model reconstructs RGB332 8'b101_010_11.
REQ-043 PIX_VALID=0 during line 3 pixel 10 -> that pixel is 8'h00,8'h00, UNDERRUN=1 and stays 1 until RESET.
REQ-044 EN dropped mid-line 50 -> the remaining 94 lines are sent, FRAME_DONE pulses once, then IDLE with VSYNC=HREF=0.
REQ-045 RESET asserted mid-HREF -> DATA=0 and HREF=0 immediately (async); after release, VSYNC rises within 2 cycles.
REQ-046 CAM_TX_TEST_PATTERN_EN defined, PAT_SEL=1 -> pixel 0 = bar 0 and pixel 22 = bar 1, with PIX_READY=0.
